// File: rtl/cvif_write_eg_cpl.sv
// Write-egress completion stage: matches AXI B responses to the per-thread
// write context queue, returns burst credits to ingress and pulses client acks.
module cvif_write_eg_cpl #(
    parameter int NUM_THREADS = 5,
    parameter int STALL_LIMIT = 1023
) (
    input  logic                       nvdla_core_clk,
    input  logic                       nvdla_core_rstn,
    // B channel: valid/ready handshake, a beat transfers when bvalid & bready.
    input  logic                       noc2cvif_axi_b_bvalid,
    output logic                       noc2cvif_axi_b_bready,
    input  logic [7:0]                 noc2cvif_axi_b_bid,
    input  logic [NUM_THREADS-1:0]     cq_rd_pvld,
    output logic [NUM_THREADS-1:0]     cq_rd_prdy,
    input  logic [3*NUM_THREADS-1:0]   cq_rd_pd,
    output logic                       eg2ig_axi_vld,
    output logic [1:0]                 eg2ig_axi_len,
    output logic                       bdma2cvif_wr_rsp_complete,
    output logic                       sdp2cvif_wr_rsp_complete,
    output logic                       pdp2cvif_wr_rsp_complete,
    output logic                       cdp2cvif_wr_rsp_complete,
    output logic                       rbk2cvif_wr_rsp_complete,
    output logic                       id_err,
    output logic                       stall_err,
    output logic [15:0]                cpl_cnt
);

    localparam logic [9:0] STALL_MAX   = 10'h3FF;
    localparam logic [9:0] STALL_LIMIT_W = 10'(STALL_LIMIT);

    logic [2:0]             tid;
    logic                   id_legal;
    logic                   head_vld;
    logic [2:0]             head_pd;
    logic                   accept_legal;
    logic                   accept_illegal;
    logic                   stall_cond;
    logic [NUM_THREADS-1:0] pop_vec;

    logic                   vld_q, vld_d;
    logic [1:0]             len_q, len_d;
    logic [NUM_THREADS-1:0] complete_q, complete_d;
    logic                   id_err_q, id_err_d;
    logic                   stall_err_q, stall_err_d;
    logic [9:0]             stall_cnt_q, stall_cnt_d;
    logic [15:0]            cpl_cnt_q, cpl_cnt_d;

    assign tid      = noc2cvif_axi_b_bid[2:0];
    assign id_legal = (noc2cvif_axi_b_bid[7:3] == 5'd0) && (32'(tid) < NUM_THREADS);

    // Head of the addressed thread's queue; unmapped thread ids see an empty head.
    always_comb begin
        head_vld = 1'b0;
        head_pd  = 3'b000;
        for (int t = 0; t < NUM_THREADS; t++) begin
            if (tid == 3'(t)) begin
                head_vld = cq_rd_pvld[t];
                head_pd  = cq_rd_pd[3*t +: 3];
            end
        end
    end

    assign accept_legal   = noc2cvif_axi_b_bvalid & id_legal & head_vld;
    assign accept_illegal = noc2cvif_axi_b_bvalid & ~id_legal;
    assign stall_cond     = noc2cvif_axi_b_bvalid & id_legal & ~head_vld;

    always_comb begin
        pop_vec = '0;
        for (int t = 0; t < NUM_THREADS; t++) begin
            if (accept_legal && (tid == 3'(t))) begin
                pop_vec[t] = 1'b1;
            end
        end
    end

    assign noc2cvif_axi_b_bready = accept_legal | accept_illegal;
    assign cq_rd_prdy            = pop_vec;

    always_comb begin
        vld_d       = accept_legal;
        len_d       = accept_legal ? head_pd[2:1] : 2'b00;
        complete_d  = (accept_legal && head_pd[0]) ? pop_vec : '0;
        cpl_cnt_d   = accept_legal ? cpl_cnt_q + 16'd1 : cpl_cnt_q;
        id_err_d    = id_err_q | accept_illegal;
        stall_cnt_d = 10'd0;
        if (stall_cond) begin
            stall_cnt_d = (stall_cnt_q == STALL_MAX) ? STALL_MAX : stall_cnt_q + 10'd1;
        end
        stall_err_d = stall_err_q | (stall_cond && (stall_cnt_d == STALL_LIMIT_W));
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (!nvdla_core_rstn) begin
            vld_q       <= 1'b0;
            len_q       <= 2'b00;
            complete_q  <= '0;
            cpl_cnt_q   <= 16'd0;
            id_err_q    <= 1'b0;
            stall_err_q <= 1'b0;
            stall_cnt_q <= 10'd0;
        end else begin
            vld_q       <= vld_d;
            len_q       <= len_d;
            complete_q  <= complete_d;
            cpl_cnt_q   <= cpl_cnt_d;
            id_err_q    <= id_err_d;
            stall_err_q <= stall_err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign eg2ig_axi_vld             = vld_q;
    assign eg2ig_axi_len             = len_q;
    assign bdma2cvif_wr_rsp_complete = complete_q[0];
    assign sdp2cvif_wr_rsp_complete  = complete_q[1];
    assign pdp2cvif_wr_rsp_complete  = complete_q[2];
    assign cdp2cvif_wr_rsp_complete  = complete_q[3];
    assign rbk2cvif_wr_rsp_complete  = complete_q[4];
    assign id_err                    = id_err_q;
    assign stall_err                 = stall_err_q;
    assign cpl_cnt                   = cpl_cnt_q;

endmodule
